// File: rtl/ptpv2_defines.sv
// Shared PTPv2 timestamp constants, queue entry width and the egress latency adder.
// Timestamps are {seconds[47:0], ns[31:0]} with ns kept below one second.
package ptpv2_defines;

    localparam int NS_PER_SEC   = 1_000_000_000;
    localparam int SEC_MSB      = 79;
    localparam int SEC_LSB      = 32;
    localparam int NS_MSB       = 31;
    localparam int TXTS_ENTRY_W = 184;

    typedef enum logic {
        IDLE       = 1'b0,
        WAIT_VALID = 1'b1
    } txq_state_t;

    // A 16-bit latency can cross at most one second boundary, so one conditional subtract suffices.
    function automatic logic [79:0] ts_add_ns(input logic [79:0] ts, input logic [15:0] lat);
        logic [32:0] sum;
        logic [47:0] sec;
        logic [31:0] ns;
        sum = {1'b0, ts[NS_MSB:0]} + {17'd0, lat};
        sec = ts[SEC_MSB:SEC_LSB];
        if (sum >= 33'(NS_PER_SEC)) begin
            ns  = 32'(sum - 33'(NS_PER_SEC));
            sec = sec + 48'd1;
        end else begin
            ns  = sum[31:0];
        end
        return {sec, ns};
    endfunction

endpackage

// File: rtl/tx_ts_fifo.sv
// Generic show-ahead sync FIFO: head valid whenever !empty (reads 0 when empty); count/empty registered.
// Push while full is dropped unless a pop happens the same cycle; clear beats push and pop.
module tx_ts_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/tx_ts_queue.sv
// TX PTP timestamp queue: capture RTC at SFD, add egress latency, pair with header on valid, queue for CPU.
// Push lands 0-1 cycles after valid; overflow drops new entries. Optional drop counter: TXTS_DROP_CNT_EN.
module tx_ts_queue
    import ptpv2_defines::*;
#(
    parameter int DEPTH         = 4,
    parameter int VALID_TIMEOUT = 255
)(
    input  logic                   rtc_clk,
    input  logic                   rtc_rst,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic [79:0]            rtc_time_i,
    input  logic [15:0]            egress_latency_i,
    input  logic                   txts_trig_i,
    input  logic                   txts_valid_i,
    input  logic [79:0]            tx_sourcePortIdentity_i,
    input  logic [15:0]            tx_seqId_i,
    input  logic [3:0]             tx_messageType_i,
    input  logic [3:0]             tx_majorSdoId_i,
    input  logic                   pop_i,
    output logic [79:0]            ts_o,
    output logic [79:0]            portid_o,
    output logic [15:0]            seqid_o,
    output logic [3:0]             msgtype_o,
    output logic [3:0]             sdoid_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   overflow_o,
    output logic                   int_txts_o
`ifdef TXTS_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt_o
`endif
);

    localparam int TW = $clog2(VALID_TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = TXTS_ENTRY_W - 80;

    txq_state_t              state;
    txq_state_t              state_nxt;
    logic [TW-1:0]           timer;
    logic [TW-1:0]           timer_nxt;
    logic [79:0]             cap_raw;
    logic [79:0]             corr_ts;
    logic                    corr_pend;
    logic                    hold_vld;
    logic [FW-1:0]           hold_fields;
    logic [FW-1:0]           fields;
    logic                    capture;
    logic                    take_direct;
    logic                    hold_set;
    logic                    push;
    logic [TXTS_ENTRY_W-1:0] push_data;
    logic [TXTS_ENTRY_W-1:0] head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic                    ovf_drop;
    logic                    cap_req;

    assign fields  = {tx_sourcePortIdentity_i, tx_seqId_i, tx_messageType_i, tx_majorSdoId_i};
    assign cap_req = txts_trig_i & enable_i;

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        capture     = 1'b0;
        take_direct = 1'b0;
        hold_set    = 1'b0;
        case (state)
            IDLE: begin
                if (cap_req) begin
                    capture   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                // A valid during the correction cycle is parked and pushed once corr_ts settles.
                if (txts_valid_i) begin
                    take_direct = ~corr_pend;
                    hold_set    = corr_pend;
                end
                if (cap_req) begin
                    capture   = 1'b1;
                    timer_nxt = '0;
                end else if (txts_valid_i) begin
                    state_nxt = IDLE;
                end else if (timer == TW'(VALID_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign push      = (take_direct | hold_vld) & ~clear_i;
    assign push_data = {corr_ts, hold_vld ? hold_fields : fields};
    assign ovf_drop  = push & fifo_full & ~pop_i;

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            state       <= IDLE;
            timer       <= '0;
            cap_raw     <= '0;
            corr_ts     <= '0;
            corr_pend   <= 1'b0;
            hold_vld    <= 1'b0;
            hold_fields <= '0;
            overflow_o  <= 1'b0;
        end else if (clear_i) begin
            state      <= IDLE;
            timer      <= '0;
            corr_pend  <= 1'b0;
            hold_vld   <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            corr_pend <= capture;
            hold_vld  <= hold_set;
            if (hold_set) hold_fields <= fields;
            if (capture)  cap_raw     <= rtc_time_i;
            if (corr_pend) corr_ts    <= ts_add_ns(cap_raw, egress_latency_i);
            if (ovf_drop) overflow_o  <= 1'b1;
        end
    end

`ifdef TXTS_DROP_CNT_EN
    logic        timeout;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    assign timeout  = (state == WAIT_VALID) & ~txts_valid_i & ~cap_req
                    & (timer == TW'(VALID_TIMEOUT - 1));
    assign drop_inc = {1'b0, ovf_drop} + {1'b0, timeout};
    assign drop_sum = {1'b0, drop_cnt_o} + {15'd0, drop_inc};

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            drop_cnt_o <= '0;
        end else begin
            drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

    tx_ts_fifo #(
        .WIDTH (TXTS_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (rtc_clk),
        .rst       (rtc_rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_i),
        .clear     (clear_i),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {ts_o, portid_o, seqid_o, msgtype_o, sdoid_o} = head;
    assign count_o    = fifo_count;
    assign empty_o    = fifo_empty;
    assign int_txts_o = ~fifo_empty;

endmodule

// File: tb/tb_tx_ts_queue.sv
// Bench for tx_ts_queue: latency-correction vector table plus hand sequences for timeout, overflow,
// full push+pop, clear collisions; queued entries are checked against a scoreboard on each pop.
module tb_tx_ts_queue;

    localparam int DEPTH = 4;
    localparam int TO    = 255;

    logic        rtc_clk  = 1'b0;
    logic        rtc_rst  = 1'b1;
    logic        enable   = 1'b0;
    logic        clear    = 1'b0;
    logic [79:0] rtc_time = '0;
    logic [15:0] lat      = '0;
    logic        trig     = 1'b0;
    logic        valid    = 1'b0;
    logic [79:0] pid      = '0;
    logic [15:0] seq      = '0;
    logic [3:0]  msg      = '0;
    logic [3:0]  sdo      = '0;
    logic        pop      = 1'b0;

    logic [79:0] ts;
    logic [79:0] portid;
    logic [15:0] seqid;
    logic [3:0]  msgtype;
    logic [3:0]  sdoid;
    logic [2:0]  count;
    logic        empty;
    logic        overflow;
    logic        irq;
`ifdef TXTS_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int            errors  = 0;
    int            checks  = 0;
    bit            exp_ovf = 1'b0;
    logic [183:0]  sb[$];

    typedef struct {
        logic [47:0] sec;
        logic [31:0] ns;
        logic [15:0] lat;
        int          dly;
        logic [47:0] esec;
        logic [31:0] ens;
    } vec_t;

    vec_t tbl[6];

    tx_ts_queue #(.DEPTH(DEPTH), .VALID_TIMEOUT(TO)) dut (
        .rtc_clk                 (rtc_clk),
        .rtc_rst                 (rtc_rst),
        .enable_i                (enable),
        .clear_i                 (clear),
        .rtc_time_i              (rtc_time),
        .egress_latency_i        (lat),
        .txts_trig_i             (trig),
        .txts_valid_i            (valid),
        .tx_sourcePortIdentity_i (pid),
        .tx_seqId_i              (seq),
        .tx_messageType_i        (msg),
        .tx_majorSdoId_i         (sdo),
        .pop_i                   (pop),
        .ts_o                    (ts),
        .portid_o                (portid),
        .seqid_o                 (seqid),
        .msgtype_o               (msgtype),
        .sdoid_o                 (sdoid),
        .count_o                 (count),
        .empty_o                 (empty),
        .overflow_o              (overflow),
        .int_txts_o              (irq)
`ifdef TXTS_DROP_CNT_EN
        ,
        .drop_cnt_o              (drop_cnt)
`endif
    );

    always #5 rtc_clk = ~rtc_clk;

    task automatic tick;
        @(posedge rtc_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [183:0] act, input logic [183:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Trigger, then a valid dly cycles later; the scoreboard learns the entry if one should be queued.
    task automatic pair(input logic [79:0] rt, input logic [15:0] l, input logic [15:0] s,
                        input logic [3:0] m, input logic [3:0] d, input logic [79:0] p,
                        input int dly, input logic [79:0] ets, input bit exp_push);
        rtc_time = rt;
        lat      = l;
        trig     = 1'b1;
        tick();
        trig = 1'b0;
        repeat (dly - 1) tick();
        seq = s; msg = m; sdo = d; pid = p;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        seq = '0; msg = '0; sdo = '0; pid = '0;
        if (exp_push) begin
            if (sb.size() < DEPTH) sb.push_back({ets, p, s, m, d});
            else exp_ovf = 1'b1;
        end
        tick();
        tick();
    endtask

    task automatic pop_check(input string name);
        logic [183:0] exp;
        exp = (sb.size() > 0) ? sb[0] : '0;
        chk(name, {ts, portid, seqid, msgtype, sdoid}, exp);
        if (sb.size() > 0) void'(sb.pop_front());
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk({name, "_cnt"}, 184'(count), 184'(sb.size()));
    endtask

    initial begin
        tbl[0] = '{48'd5,              32'd100,         16'd40,    10, 48'd5,              32'd140};
        tbl[1] = '{48'hFFFF_FFFF_FFFF, 32'd999_999_990, 16'd20,    3,  48'd0,              32'd10};
        tbl[2] = '{48'd7,              32'd999_999_999, 16'd1,     1,  48'd8,              32'd0};
        tbl[3] = '{48'd1,              32'd0,           16'hFFFF,  2,  48'd1,              32'd65535};
        tbl[4] = '{48'h1234_5678_9ABC, 32'd999_990_000, 16'd9_999, 5,  48'h1234_5678_9ABC, 32'd999_999_999};
        tbl[5] = '{48'd2,              32'd999_950_000, 16'd50_000, 1, 48'd3,              32'd0};

        repeat (3) tick();
        chk("rst_count", 184'(count), 184'(0));
        chk("rst_empty", 184'(empty), 184'(1));
        chk("rst_ovf",   184'(overflow), 184'(0));
        chk("rst_irq",   184'(irq), 184'(0));
        chk("rst_head",  {ts, portid, seqid, msgtype, sdoid}, '0);
        rtc_rst = 1'b0;
        enable  = 1'b1;
        tick();

        // valid with no preceding trigger
        seq = 16'h7; valid = 1'b1;
        tick();
        valid = 1'b0; seq = '0;
        tick();
        chk("idle_valid", 184'(empty), 184'(1));

        for (int i = 0; i < 6; i++) begin
            chk("tbl_empty_pre", 184'(empty), 184'(1));
            pair({tbl[i].sec, tbl[i].ns}, tbl[i].lat, 16'(100 + i), 4'(i), 4'(15 - i),
                 {16'hABCD, 32'(i), 32'h600D_F00D}, tbl[i].dly, {tbl[i].esec, tbl[i].ens}, 1'b1);
            chk("tbl_empty", 184'(empty), 184'(0));
            chk("tbl_irq",   184'(irq), 184'(1));
            chk("tbl_count", 184'(count), 184'(1));
            pop_check("tbl_head");
            chk("tbl_empty_post", 184'(empty), 184'(1));
            chk("tbl_irq_post",   184'(irq), 184'(0));
        end

        // valid exactly at the timeout limit is accepted, one cycle later it is not
        pair({48'd9, 32'd0}, 16'd5, 16'h77, 4'h3, 4'h1, 80'h55, TO, {48'd9, 32'd5}, 1'b1);
        chk("to_edge_count", 184'(count), 184'(1));
        pop_check("to_edge_head");
        pair({48'd9, 32'd0}, 16'd5, 16'h78, 4'h3, 4'h1, 80'h55, TO + 1, {48'd9, 32'd5}, 1'b0);
        chk("to_late_empty", 184'(empty), 184'(1));
`ifdef TXTS_DROP_CNT_EN
        chk("to_drop_cnt", 184'(drop_cnt), 184'(1));
`endif

        // second trigger discards the first capture
        rtc_time = {48'd9, 32'd0}; trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        pair({48'd9, 32'd500}, 16'd40, 16'h21, 4'h2, 4'h0, 80'h1, 2, {48'd9, 32'd540}, 1'b1);
        chk("recap_count", 184'(count), 184'(1));
        pop_check("recap_head");

        // trig and valid together: old capture pushed, new one waits for its own valid
        lat = 16'd0;
        rtc_time = {48'd20, 32'd1000}; trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        rtc_time = {48'd21, 32'd2000}; trig = 1'b1; valid = 1'b1; seq = 16'h31;
        tick();
        trig = 1'b0; valid = 1'b0; seq = '0;
        sb.push_back({48'd20, 32'd1000, 80'd0, 16'h31, 4'd0, 4'd0});
        tick();
        tick();
        valid = 1'b1; seq = 16'h32;
        tick();
        valid = 1'b0; seq = '0;
        sb.push_back({48'd21, 32'd2000, 80'd0, 16'h32, 4'd0, 4'd0});
        tick();
        tick();
        chk("tv_count", 184'(count), 184'(2));
        pop_check("tv_head0");
        pop_check("tv_head1");

        // disabled: no capture; a capture already pending still completes
        enable = 1'b0;
        pair({48'd30, 32'd30}, 16'd10, 16'h5F, 4'h1, 4'h1, 80'h9, 2, 80'd0, 1'b0);
        chk("dis_count", 184'(count), 184'(0));
        enable = 1'b1;
        rtc_time = {48'd30, 32'd30}; lat = 16'd10; trig = 1'b1;
        tick();
        trig = 1'b0; enable = 1'b0;
        tick();
        tick();
        valid = 1'b1; seq = 16'h60;
        tick();
        valid = 1'b0; seq = '0;
        sb.push_back({48'd30, 32'd40, 80'd0, 16'h60, 4'd0, 4'd0});
        tick();
        tick();
        chk("pend_count", 184'(count), 184'(1));
        pop_check("pend_head");
        enable = 1'b1;

        // five pushes into a four-deep queue
        for (int k = 1; k <= 5; k++) begin
            pair({48'd1, 32'(k)}, 16'd0, 16'(k), 4'h4, 4'h2, 80'h77, 2, {48'd1, 32'(k)}, 1'b1);
        end
        chk("ovf_count", 184'(count), 184'(4));
        chk("ovf_flag",  184'(overflow), 184'(exp_ovf));
`ifdef TXTS_DROP_CNT_EN
        chk("ovf_drop_cnt", 184'(drop_cnt), 184'(2));
`endif
        for (int k = 0; k < 4; k++) pop_check("ovf_pop");
        chk("ovf_sticky", 184'(overflow), 184'(1));
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("empty_pop", 184'(count), 184'(0));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_ovf = 1'b0;
        chk("clr_ovf", 184'(overflow), 184'(0));
`ifdef TXTS_DROP_CNT_EN
        chk("clr_drop_cnt", 184'(drop_cnt), 184'(0));
`endif

        // full queue, push and pop in the same cycle
        for (int k = 11; k <= 14; k++) begin
            pair({48'd2, 32'(k)}, 16'd0, 16'(k), 4'h1, 4'h1, 80'h3, 2, {48'd2, 32'(k)}, 1'b1);
        end
        rtc_time = {48'd3, 32'd3}; lat = 16'd0; trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        seq = 16'd15; valid = 1'b1; pop = 1'b1;
        chk("fpp_head_pre", {ts, portid, seqid, msgtype, sdoid}, sb[0]);
        void'(sb.pop_front());
        sb.push_back({48'd3, 32'd3, 80'd0, 16'd15, 4'd0, 4'd0});
        tick();
        valid = 1'b0; pop = 1'b0; seq = '0;
        tick();
        chk("fpp_count", 184'(count), 184'(4));
        chk("fpp_ovf",   184'(overflow), 184'(0));
        chk("fpp_head",  {ts, portid, seqid, msgtype, sdoid}, sb[0]);

        // clear collides with a push
        rtc_time = {48'd4, 32'd4}; trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        seq = 16'h40; valid = 1'b1; clear = 1'b1;
        tick();
        valid = 1'b0; clear = 1'b0; seq = '0;
        sb.delete();
        tick();
        chk("clr_count", 184'(count), 184'(0));
        chk("clr_ovf2",  184'(overflow), 184'(0));
        chk("clr_empty", 184'(empty), 184'(1));
        valid = 1'b1; seq = 16'h41;
        tick();
        valid = 1'b0; seq = '0;
        tick();
        chk("clr_idle", 184'(count), 184'(0));
        pair({48'd6, 32'd6}, 16'd4, 16'h50, 4'h5, 4'h6, 80'hBEEF, 2, {48'd6, 32'd10}, 1'b1);
        chk("clr_next_count", 184'(count), 184'(1));
        pop_check("clr_next_head");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_ts_queue.md
Name: tx_ts_queue

Overview:
- Downstream consumer of the tx timestamp engine's rtc_clk-side outputs (txts_trig/txts_valid plus parsed PTP header fields).
- On each trigger, captures the free-running RTC time and applies the fixed egress latency correction.
- When the same frame is confirmed as a PTP event, pairs the corrected timestamp with seqId, messageType, majorSdoId and sourcePortIdentity.
- Queues the pairs in a small FIFO for CPU readout, with a level interrupt.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- VALID_TIMEOUT, 255, max rtc_clk cycles from trigger to valid before the capture is discarded; minimum 1.

Ports:
- rtc_clk  in  1  RTC clock domain.
- rtc_rst  in  1  asynchronous, active-high reset.
- enable_i  in  1  capture enable (tsu_cfg-derived).
- clear_i  in  1  synchronous flush pulse.
- rtc_time_i  in  80  current RTC time: [79:32] seconds, [31:0] ns (< 1e9).
- egress_latency_i  in  16  ns added to captured time.
- txts_trig_i  in  1  1-cycle pulse at SFD.
- txts_valid_i  in  1  1-cycle pulse: frame is a PTP event; header fields valid this cycle.
- tx_sourcePortIdentity_i  in  80  header field.
- tx_seqId_i  in  16  header field.
- tx_messageType_i  in  4  header field.
- tx_majorSdoId_i  in  4  header field.
- pop_i  in  1  CPU read strobe; pops the head entry.
- ts_o  out  80  head timestamp.
- portid_o  out  80  head sourcePortIdentity.
- seqid_o  out  16  head seqId.
- msgtype_o  out  4  head messageType.
- sdoid_o  out  4  head majorSdoId.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- empty_o  out  1  FIFO empty.
- overflow_o  out  1  sticky overflow flag.
- int_txts_o  out  1  level interrupt; equals !empty_o.

Behaviour:
- Reset values:
  - All outputs 0 except empty_o=1.
  - FSM in IDLE; FIFO pointers and count 0.
- FSM states: IDLE, WAIT_VALID.
  - IDLE, txts_trig_i & enable_i: latch rtc_time_i into the capture register, clear the timer, go to WAIT_VALID.
  - IDLE, txts_valid_i: ignored.
  - WAIT_VALID, txts_valid_i: push {corrected ts, fields}, go to IDLE.
  - WAIT_VALID, txts_trig_i without valid: recapture, restart the timer, stay in WAIT_VALID. The previous capture is discarded silently.
  - WAIT_VALID, trig and valid in the same cycle: push using the old capture, then recapture and stay in WAIT_VALID.
  - WAIT_VALID, timer reaches VALID_TIMEOUT: go to IDLE with no push.
  - enable_i low: no new captures; a pending WAIT_VALID still completes. The FIFO is retained.
- Latency correction:
  - Computed in the cycle after capture, before any valid pulse can be accepted. valid arriving the cycle after trig is held until correction completes; the push is at most one cycle late.
  - ns_sum = ns + egress_latency_i, computed 33-bit.
  - If ns_sum >= 1_000_000_000: ns = ns_sum - 1e9 and seconds = seconds + 1 (48-bit modulo wrap).
- FIFO:
  - Show-ahead. Head fields are valid whenever empty_o=0; they read 0 when empty.
  - Push when full without pop: entry dropped, overflow_o set.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- Registered outputs: count_o, empty_o and int_txts_o update the cycle after a push or pop.
- clear_i:
  - Empties the FIFO, clears overflow_o, returns the FSM to IDLE.
  - Has priority over a push or pop in the same cycle.
- Reset mid-operation: asynchronous return to reset values; in-flight captures are lost.

Optional Feature:
- Macro: TXTS_DROP_CNT_EN.
- When defined, adds output drop_cnt_o [15:0]:
  - Increments on every overflow drop and on every timeout discard.
  - Saturates at 0xFFFF.
  - Cleared by clear_i and by reset.
- When not defined: no port and no logic; overflow_o is unchanged.

Decomposition:
- Shared package ptpv2_defines gets:
  - NS_PER_SEC = 1_000_000_000.
  - Timestamp field offsets (SEC_MSB=79, SEC_LSB=32, NS_MSB=31).
  - The entry width constant TXTS_ENTRY_W = 184.
- One sub-module: tx_ts_fifo, a generic show-ahead sync FIFO with parameters WIDTH and DEPTH, ports push/pop/clear/full/empty/count.
- The FSM and latency adder stay in the top module.

Test Plan:
- trig at rtc_time={sec=5, ns=100}, latency=40, valid 10 cycles later, then pop → head ts={5,140}, seqid/msgtype match the valid-cycle inputs; empty_o 1→0→1; int_txts_o follows.
- rtc_time={sec=0x0000FFFFFFFFFFFF, ns=999_999_990}, latency=20, valid 3 cycles after trig → ts={sec=0, ns=10}.
- trig, then no valid for VALID_TIMEOUT cycles, then a late valid → FIFO stays empty; drop_cnt_o=1 with TXTS_DROP_CNT_EN.
- DEPTH=4, 5 trig/valid pairs with seqId 1..5, no pops → count_o=4, overflow_o=1; pops return seqIds 1,2,3,4.
- FIFO full, push and pop in the same cycle → count_o stays 4, head advances to the next seqId, overflow_o not set.
- clear_i asserted in the same cycle as a push → count_o=0, overflow_o=0, FSM in IDLE; next trig/valid pair queues normally.
